// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader.
// State encodings and build-wide defaults.
package uart_loader_pkg;

  localparam int INST_MEM_ADDR_SIZE = 8;
  localparam int LOADER_TIMEOUT     = 50000000;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    CHK,
    WORD,
    WRITE,
    DONE,
    ERROR
  } ld_state_e;

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte idle counter for the UART loader.
// expired flags the last allowed idle cycle.
module loader_timeout #(
  parameter int TIMEOUT = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (run && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_loader.sv
// Streams a word-count-prefixed program from the UART
// into instruction memory, holding the CPU until done.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W  = INST_MEM_ADDR_SIZE,
  parameter int TIMEOUT = LOADER_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxReady,
  input  logic [7:0]        rxData,
  output logic              rxClear,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memData,
  output logic              memWren,
  output logic              cpuHold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  ld_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   data_q, data_d;
  logic          clr_q, clr_d;

  logic          accept;
  logic          tmo_run;
  logic          tmo_clear;
  logic          expired;
  logic [ADDR_W:0] idx_inc;

  // rxReady is a level; the clear cycle masks the stale flag
  assign accept = rxReady && !clr_q &&
                  (state_q inside {CNT_HI, CNT_LO, WORD});
  assign tmo_run   = state_q inside {CNT_LO, WORD};
  assign tmo_clear = accept || !tmo_run;
  assign idx_inc   = idx_q + 1'b1;

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (tmo_clear),
    .run     (tmo_run),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bidx_d  = bidx_q;
    data_d  = data_q;
    clr_d   = accept;
    unique case (state_q)
      CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = rxData;
          state_d     = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          cnt_d[7:0] = rxData;
          state_d    = CHK;
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      CHK: begin
        idx_d  = '0;
        bidx_d = '0;
        if (cnt_q == 16'd0 || 17'(cnt_q) > MAX_N)
          state_d = ERROR;
        else
          state_d = WORD;
      end
      WORD: begin
        if (accept) begin
          data_d = {data_q[23:0], rxData};
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == 2'd3)
            state_d = WRITE;
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      WRITE: begin
        idx_d  = idx_inc;
        bidx_d = '0;
        if (16'(idx_inc) == cnt_q)
          state_d = DONE;
        else
          state_d = WORD;
      end
      DONE:  state_d = DONE;
      ERROR: state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CNT_HI;
      cnt_q   <= '0;
      idx_q   <= '0;
      bidx_q  <= '0;
      data_q  <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bidx_q  <= bidx_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
    end
  end

  assign rxClear = clr_q;
  assign memAddr = idx_q[ADDR_W-1:0];
  assign memData = data_q;
  assign memWren = (state_q == WRITE);
  assign cpuHold = (state_q != DONE);
  assign done    = (state_q == DONE);
  assign error   = (state_q == ERROR);

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: directed frames,
// expected writes queued, monitor pops on memWren.
module tb_uart_loader;

  localparam int AW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxReady = 1'b0;
  logic [7:0]    rxData = 8'h00;
  logic          rxClear;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic          memWren;
  logic          cpuHold;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic prev_clr = 1'b0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;

  uart_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .rxReady (rxReady),
    .rxData  (rxData),
    .rxClear (rxClear),
    .memAddr (memAddr),
    .memData (memData),
    .memWren (memWren),
    .cpuHold (cpuHold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h",
                 memAddr, memData);
      end else begin
        exp_e = exp_q.pop_front();
        if ({memAddr, memData} !== exp_e) begin
          errors++;
          $display("FAIL write got=%0h/%08h want=%0h/%08h",
                   memAddr, memData, exp_e[AW+31:32], exp_e[31:0]);
        end
      end
    end
    if (rxClear) begin
      pulses++;
      checks++;
      if (prev_clr) begin
        errors++;
        $display("FAIL rxclear_width got=2+ cycles want=1");
      end
    end
    prev_clr = rxClear;
  end

  task automatic chk(input string name, input logic [35:0] act,
                     input logic [35:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int lag);
    logic got;
    got = 1'b0;
    rxData  = b;
    rxReady = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = rxClear;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout got=no rxClear want=rxClear b=%0h", b);
    end
    repeat (lag) @(negedge clk);
    rxReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  initial begin
    int p0;
    logic [7:0] w [0:3];

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold", cpuHold, 1);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_outs", {rxClear, memWren, memAddr}, 0);
    chk("reset_data", memData, 0);
    rst = 1'b1;
    @(negedge clk);

    // two-word frame and latency to release
    push_exp(0, 32'h12345678);
    push_exp(1, 32'h9ABCDEF0);
    p0 = pulses;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_byte(8'h9A, 0); send_byte(8'hBC, 0);
    send_byte(8'hDE, 0); send_byte(8'hF0, 0);
    chk("frame2_done", done, 1);
    chk("frame2_hold", cpuHold, 0);
    chk("frame2_err", error, 0);
    chk("frame2_pulses", pulses - p0, 10);
    chk("frame2_pending", exp_q.size(), 0);
    p0 = pulses;
    rxReady = 1'b1;
    rxData  = 8'h55;
    repeat (5) @(negedge clk);
    rxReady = 1'b0;
    chk("done_ignores_rx", pulses - p0, 0);
    chk("done_sticky", done, 1);

    // zero count
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    chk("zero_err", error, 1);
    chk("zero_hold", cpuHold, 1);
    chk("zero_done", done, 0);

    // full-depth load
    do_reset();
    for (int i = 0; i < 16; i++)
      push_exp(i, {8'h10 + 8'(i), 8'h20 + 8'(i),
                   8'h30 + 8'(i), 8'h40 + 8'(i)});
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    for (int i = 0; i < 16; i++) begin
      w[0] = 8'h10 + 8'(i); w[1] = 8'h20 + 8'(i);
      w[2] = 8'h30 + 8'(i); w[3] = 8'h40 + 8'(i);
      for (int j = 0; j < 4; j++) send_byte(w[j], 0);
    end
    chk("full_done", done, 1);
    chk("full_hold", cpuHold, 0);
    chk("full_pending", exp_q.size(), 0);

    // count one past depth
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    repeat (3) @(negedge clk);
    chk("over_err", error, 1);
    chk("over_done", done, 0);

    // mid-frame idle timeout boundary
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    repeat (98) @(negedge clk);
    chk("tmo_before", error, 0);
    @(negedge clk);
    chk("tmo_at", error, 1);
    chk("tmo_hold", cpuHold, 1);

    // long idle before the count is fine
    do_reset();
    repeat (1000) @(negedge clk);
    chk("idle_cnt_hi", error, 0);

    // rxReady held across the masked clear cycle
    push_exp(0, 32'hCAFEBABE);
    p0 = pulses;
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'hCA, 1); send_byte(8'hFE, 1);
    send_byte(8'hBA, 1); send_byte(8'hBE, 1);
    chk("held_pulses", pulses - p0, 6);
    chk("held_done", done, 1);
    chk("held_pending", exp_q.size(), 0);

    // reset mid-word, then a clean frame
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    chk("rst_mid_addr", memAddr, 0);
    chk("rst_mid_data", memData, 0);
    push_exp(0, 32'h11223344);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    chk("rst_mid_done", done, 1);
    chk("rst_mid_pending", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
